// File: rtl/gate_vector_driver.sv
// Self-test stimulus stage for a 2-input gate: walks {a,b} through 00..11,
// samples f after each hold and checks it against a truth table.
module gate_vector_driver #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXP_TABLE   = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_FINISH
    } state_t;

    localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_idx;
    logic [7:0] r_hc;
    logic       r_a;
    logic       r_b;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fvec;

    logic       w_last_hold;
    logic       w_mismatch;
    logic [2:0] w_err_nxt;

    assign w_last_hold = (r_state == S_APPLY) && (r_hc == HC_LAST);
    assign w_mismatch  = w_last_hold && (f != EXP_TABLE[r_idx]);
    assign w_err_nxt   = r_err + 3'(w_mismatch);

    assign a         = r_a;
    assign b         = r_b;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fvec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_APPLY;
                end
            end
            S_APPLY: begin
                busy = 1'b1;
                if (w_last_hold && (r_idx == 2'd3)) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_hc   <= 8'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_fvec <= 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx  <= 2'd0;
                        r_hc   <= 8'd0;
                        r_a    <= 1'b0;
                        r_b    <= 1'b0;
                        r_pass <= 1'b0;
                        r_err  <= 3'd0;
                        r_fvec <= 4'd0;
                    end
                end
                S_APPLY: begin
                    if (w_last_hold) begin
                        r_hc  <= 8'd0;
                        r_err <= w_err_nxt;
                        if (w_mismatch) begin
                            r_fvec[r_idx] <= 1'b1;
                        end
                        // pass uses the updated count so a last-vector miss counts
                        if (r_idx == 2'd3) begin
                            r_a    <= 1'b0;
                            r_b    <= 1'b0;
                            r_pass <= (w_err_nxt == 3'd0);
                        end else begin
                            r_idx        <= r_idx + 2'd1;
                            {r_a, r_b}   <= r_idx + 2'd1;
                        end
                    end else begin
                        r_hc <= r_hc + 8'd1;
                    end
                end
                S_FINISH: begin
                    r_idx <= 2'd0;
                end
                default: begin
                    r_idx <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_driver.sv
// Scoreboard bench for gate_vector_driver: directed runs on an H=4 and an
// H=1 instance, with a negedge monitor checking every done pulse.
module tb_gate_vector_driver;

    localparam int G_AND  = 0;
    localparam int G_ZERO = 1;
    localparam int G_OR   = 2;

    typedef struct {
        int cyc;
        int pass;
        int err;
        int fvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic       a4, b4, f4, busy4, done4, pass4;
    logic       a1, b1, f1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [3:0] fv4, fv1;

    int mode4 = G_AND;
    int mode1 = G_AND;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic gate(input int m, input logic x, input logic y);
        case (m)
            G_AND:   return x & y;
            G_OR:    return x | y;
            default: return 1'b0;
        endcase
    endfunction

    always_comb f4 = gate(mode4, a4, b4);
    always_comb f1 = gate(mode1, a1, b1);

    gate_vector_driver #(.HOLD_CYCLES(4), .EXP_TABLE(4'b1000)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a(a4), .b(b4), .f(f4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_vec(fv4)
    );

    gate_vector_driver #(.HOLD_CYCLES(1), .EXP_TABLE(4'b1000)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ab4"}, int'({a4, b4}), 0);
        chk({nm, "_busy4"}, int'(busy4), 0);
        chk({nm, "_done4"}, int'(done4), 0);
        chk({nm, "_pass4"}, int'(pass4), 0);
        chk({nm, "_err4"}, int'(err4), 0);
        chk({nm, "_fv4"}, int'(fv4), 0);
        chk({nm, "_busy1"}, int'(busy1), 0);
        chk({nm, "_pass1"}, int'(pass1), 0);
    endtask

    // Monitor: pop the expected result whenever a done pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done4_unexpected: done seen at cycle %0d, none expected", cyc);
            end else begin
                e = q4.pop_front();
                chk("done4_cycle", cyc, e.cyc);
                chk("done4_busy", int'(busy4), 1);
                chk("done4_pass", int'(pass4), e.pass);
                chk("done4_err", int'(err4), e.err);
                chk("done4_fvec", int'(fv4), e.fvec);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done1_unexpected: done seen at cycle %0d, none expected", cyc);
            end else begin
                e = q1.pop_front();
                chk("done1_cycle", cyc, e.cyc);
                chk("done1_busy", int'(busy1), 1);
                chk("done1_pass", int'(pass1), e.pass);
                chk("done1_err", int'(err1), e.err);
                chk("done1_fvec", int'(fv1), e.fvec);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1
    task automatic run4(input int m, input int p, input int e, input int fv);
        exp_t x;
        mode4 = m;
        x.cyc = cyc + 17;
        x.pass = p;
        x.err = e;
        x.fvec = fv;
        q4.push_back(x);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic run1(input int m, input int p, input int e, input int fv);
        exp_t x;
        mode1 = m;
        x.cyc = cyc + 5;
        x.pass = p;
        x.err = e;
        x.fvec = fv;
        q1.push_back(x);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic pulse4();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    initial begin
        #2;
        chk_idle("por");
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        chk_idle("post_rst");

        // Correct AND gate: vector sequence and busy for cycles 1..16
        run4(G_AND, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("and_ab_c%0d", i), int'({a4, b4}), (i - 1) / 4);
            chk($sformatf("and_busy_c%0d", i), int'(busy4), 1);
            @(negedge clk);
        end
        chk("and_finish_ab", int'({a4, b4}), 0);
        wait_cyc(2);
        chk("and_idle_busy", int'(busy4), 0);
        chk("and_hold_pass", int'(pass4), 1);

        // f stuck at 0: only vector 3 mismatches
        run4(G_ZERO, 0, 1, 4'b1000);
        wait_cyc(18);

        // OR gate, then a restart with AND clears results on the start edge
        run4(G_OR, 0, 2, 4'b0110);
        wait_cyc(17);
        chk("or_hold_err", int'(err4), 2);
        chk("or_hold_fvec", int'(fv4), 6);
        run4(G_AND, 1, 0, 0);
        chk("restart_err_clr", int'(err4), 0);
        chk("restart_fvec_clr", int'(fv4), 0);
        chk("restart_pass_clr", int'(pass4), 0);
        wait_cyc(18);

        // Starts during APPLY (cycle 5) and FINISH (cycle 17) are ignored
        run4(G_AND, 1, 0, 0);
        wait_cyc(4);
        pulse4();
        wait_cyc(11);
        pulse4();
        run4(G_AND, 1, 0, 0);
        wait_cyc(18);

        // Reset mid-run aborts it with no done pulse
        run4(G_AND, 1, 0, 0);
        wait_cyc(5);
        #2;
        rst = 1'b1;
        q4.delete();
        #1;
        chk_idle("midrun_rst");
        wait_cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_idle($sformatf("rel%0d", i));
            @(negedge clk);
        end
        run4(G_AND, 1, 0, 0);
        wait_cyc(18);

        // H=1 instance: done 5 cycles after start
        run1(G_AND, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("h1_ab_c%0d", i), int'({a1, b1}), i - 1);
            @(negedge clk);
        end
        wait_cyc(3);
        run1(G_ZERO, 0, 1, 4'b1000);
        wait_cyc(6);
        run1(G_OR, 0, 2, 4'b0110);
        wait_cyc(6);

        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
